// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: write-response codes and the write-initiator
// state encoding.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    RESP
  } wr_state_e;

endpackage

// File: rtl/axi_lite_write_master_if.sv
// AXI4-Lite write-side channels (AW, W, B) between an initiator and a slave.
interface axi_lite_write_master_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/axi_lite_write_master.sv
// Single-beat AXI4-Lite write initiator: one command in, AW+W out, B back as a
// one-cycle completion pulse, with a sticky timeout on stalled transactions.
module axi_lite_write_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_data,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  axi_lite_write_master_if.master axi,
  output logic                    done_valid,
  output logic [1:0]              done_resp,
  output logic                    timeout
);

  localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  wr_state_e        state;
  logic [CNT_W-1:0] cycle_cnt;
  logic             aw_done;
  logic             w_done;

  logic accept;
  logic aw_fire;
  logic w_fire;
  logic b_fire;

  assign accept  = (state == IDLE) && cmd_valid && cmd_ready;
  assign aw_fire = axi.awvalid && axi.awready;
  assign w_fire  = axi.wvalid && axi.wready;
  assign b_fire  = axi.bvalid && axi.bready;

  // NOTE: every register here is assigned with <=, so each branch below reads
  // the pre-edge value of state, the done flags and the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cycle_cnt   <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      cmd_ready   <= 1'b0;
      axi.awaddr  <= '0;
      axi.awvalid <= 1'b0;
      axi.wdata   <= '0;
      axi.wstrb   <= '0;
      axi.wvalid  <= 1'b0;
      axi.bready  <= 1'b0;
      done_valid  <= 1'b0;
      done_resp   <= RESP_OKAY;
      timeout     <= 1'b0;
    end else begin
      done_valid <= 1'b0;

      // Outstanding-cycle counter; the transaction keeps going after expiry
      // because AXI does not allow a valid to be withdrawn.
      if (state != IDLE && cycle_cnt != CNT_MAX) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
        if (cycle_cnt == CNT_MAX - CNT_W'(1)) begin
          timeout <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            cmd_ready   <= 1'b0;
            axi.awaddr  <= cmd_addr;
            axi.wdata   <= cmd_data;
            axi.wstrb   <= cmd_strb;
            axi.awvalid <= 1'b1;
            axi.wvalid  <= 1'b1;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            timeout     <= 1'b0;
            cycle_cnt   <= '0;
            state       <= SEND;
          end
        end

        SEND: begin
          if (aw_fire) begin
            axi.awvalid <= 1'b0;
            aw_done     <= 1'b1;
          end
          if (w_fire) begin
            axi.wvalid <= 1'b0;
            w_done     <= 1'b1;
          end
          // AW and W may finish on the same edge or on different edges.
          if ((aw_done || aw_fire) && (w_done || w_fire)) begin
            axi.bready <= 1'b1;
            state      <= RESP;
          end
        end

        RESP: begin
          if (b_fire) begin
            axi.bready <= 1'b0;
            done_valid <= 1'b1;
            done_resp  <= axi.bresp;
            cmd_ready  <= 1'b1;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_write_master.sv
// Self-checking bench: a schedule-driven slave plus a per-cycle timeline model
// of every expected output, with literal latency/response pins for key cases.
module tb_axi_lite_write_master;
  import axi_lite_pkg::*;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic [SW-1:0] cmd_strb;
  logic          done_valid;
  logic [1:0]    done_resp;
  logic          timeout;

  always #5 clk = ~clk;

  axi_lite_write_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_lite_write_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_strb(cmd_strb),
    .axi(bus),
    .done_valid(done_valid), .done_resp(done_resp), .timeout(timeout)
  );

  // One planned write: idle gap before it, slave ready delays, where bvalid
  // rises relative to the cycle bready is due, and the command contents.
  typedef struct {
    int            gap;
    int            da;
    int            dw;
    int            bs_rel;
    logic [1:0]    resp;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
  } txn_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  txn_t plan[$];
  txn_t cur;
  bit   active = 1'b0;
  int   acc = 0, a_c = 0, w_c = 0, r_c = 0, bs_c = 0, h = 0;
  int   ready_from = 1 << 30;
  int   last_done  = -1;
  logic [1:0] last_resp = 2'b00;
  bit   last_to  = 1'b0;
  int   idle_cnt = 0;

  logic          cmp_en = 1'b0;
  logic          exp_cmd_ready, exp_awvalid, exp_wvalid, exp_bready, exp_done, exp_timeout;
  logic [1:0]    exp_resp;
  logic [AW-1:0] exp_awaddr;
  logic [DW-1:0] exp_wdata;
  logic [SW-1:0] exp_wstrb;

  int            acc_log[$];
  int            done_log[$];
  logic [1:0]    resp_log[$];
  int            aw_hs_cyc = -1, w_hs_cyc = -1, to_rise = -1;
  logic [AW-1:0] aw_hs_addr;
  logic [DW-1:0] w_hs_data;
  logic [SW-1:0] w_hs_strb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic txn_t mk(input int gap, input int da, input int dw, input int bs_rel,
                              input logic [1:0] resp, input logic [AW-1:0] addr,
                              input logic [DW-1:0] data, input logic [SW-1:0] strb);
    txn_t x;
    x.gap = gap; x.da = da; x.dw = dw; x.bs_rel = bs_rel;
    x.resp = resp; x.addr = addr; x.data = data; x.strb = strb;
    return x;
  endfunction

  // Advance one clock and derive this cycle's slave inputs and expected outputs
  // from the transaction timeline (t = cycles since the accept edge).
  task automatic step();
    int t;
    @(posedge clk);
    #1;
    cyc++;
    if (active && (cyc - acc) > h) begin
      active    = 1'b0;
      last_done = cyc;
      last_resp = cur.resp;
      last_to   = (h >= TO);
    end
    cmd_valid   = 1'b0;
    cmd_addr    = AW'($urandom);
    cmd_data    = $urandom;
    cmd_strb    = SW'($urandom);
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    bus.bresp   = 2'($urandom);
    if (active) begin
      t = cyc - acc;
      cmd_valid   = 1'($urandom);
      bus.awready = (t == a_c) ? 1'b1 : (t > a_c) ? 1'($urandom) : 1'b0;
      bus.wready  = (t == w_c) ? 1'b1 : (t > w_c) ? 1'($urandom) : 1'b0;
      bus.bvalid  = (t >= bs_c) && (t <= h);
      if (bus.bvalid) bus.bresp = cur.resp;
      exp_cmd_ready = 1'b0;
      exp_awvalid   = (t <= a_c);
      exp_wvalid    = (t <= w_c);
      exp_bready    = (t >= r_c);
      exp_done      = 1'b0;
      exp_timeout   = ((t - 1) >= TO);
    end else begin
      exp_cmd_ready = (cyc >= ready_from);
      exp_awvalid   = 1'b0;
      exp_wvalid    = 1'b0;
      exp_bready    = 1'b0;
      exp_done      = (cyc == last_done);
      exp_resp      = last_resp;
      exp_timeout   = last_to;
      if (!exp_cmd_ready) begin
        cmd_valid = 1'($urandom);
      end else if (plan.size() > 0 && idle_cnt >= plan[0].gap) begin
        cur       = plan.pop_front();
        cmd_valid = 1'b1;
        cmd_addr  = cur.addr;
        cmd_data  = cur.data;
        cmd_strb  = cur.strb;
        acc       = cyc;
        acc_log.push_back(cyc);
        active    = 1'b1;
        idle_cnt  = 0;
        a_c  = 1 + cur.da;
        w_c  = 1 + cur.dw;
        r_c  = ((a_c > w_c) ? a_c : w_c) + 1;
        bs_c = r_c + cur.bs_rel;
        if (bs_c < 1) bs_c = 1;
        h    = (bs_c > r_c) ? bs_c : r_c;
        exp_awaddr = cur.addr;
        exp_wdata  = cur.data;
        exp_wstrb  = cur.strb;
      end else begin
        idle_cnt++;
      end
    end
  endtask

  task automatic run_batch();
    int n = 0;
    acc_log.delete();
    done_log.delete();
    resp_log.delete();
    while ((plan.size() > 0 || active) && n < 2000) begin
      step();
      n++;
    end
    check("batch_within_budget", (n < 2000), 1'b1);
    step();
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmd_ready",  cmd_ready,   exp_cmd_ready);
      check("awvalid",    bus.awvalid, exp_awvalid);
      check("wvalid",     bus.wvalid,  exp_wvalid);
      check("bready",     bus.bready,  exp_bready);
      check("done_valid", done_valid,  exp_done);
      check("timeout",    timeout,     exp_timeout);
      if (exp_awvalid) check("awaddr", bus.awaddr, exp_awaddr);
      if (exp_wvalid) begin
        check("wdata", bus.wdata, exp_wdata);
        check("wstrb", bus.wstrb, exp_wstrb);
      end
      if (exp_done) check("done_resp", done_resp, exp_resp);
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done_valid) begin
        done_log.push_back(cyc);
        resp_log.push_back(done_resp);
      end
      if (bus.awvalid && bus.awready) begin
        aw_hs_cyc  = cyc;
        aw_hs_addr = bus.awaddr;
      end
      if (bus.wvalid && bus.wready) begin
        w_hs_cyc  = cyc;
        w_hs_data = bus.wdata;
        w_hs_strb = bus.wstrb;
      end
      if (timeout && to_rise < 0) to_rise = cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_done;
    int n;
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_addr    = '0;
    cmd_data    = '0;
    cmd_strb    = '0;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    bus.bresp   = 2'b00;

    #12;
    check("rst_cmd_ready",  cmd_ready,   1'b0);
    check("rst_awvalid",    bus.awvalid, 1'b0);
    check("rst_wvalid",     bus.wvalid,  1'b0);
    check("rst_bready",     bus.bready,  1'b0);
    check("rst_done_valid", done_valid,  1'b0);
    check("rst_done_resp",  done_resp,   2'b00);
    check("rst_timeout",    timeout,     1'b0);
    check("rst_awaddr",     bus.awaddr,  '0);
    check("rst_wdata",      bus.wdata,   '0);

    step();
    step();
    rst_n      = 1'b1;
    ready_from = cyc + 1;
    cmp_en     = 1'b1;

    // Best case: handshakes at edge 1, done in cycle 3 with OKAY.
    plan.push_back(mk(0, 0, 0, 0, RESP_OKAY, 4'h4, 32'hDEADBEEF, 4'hF));
    run_batch();
    check("t1_aw_hs_cycle", aw_hs_cyc - acc_log[0], 1);
    check("t1_aw_hs_addr",  aw_hs_addr, 4'h4);
    check("t1_w_hs_cycle",  w_hs_cyc - acc_log[0], 1);
    check("t1_w_hs_data",   w_hs_data, 32'hDEADBEEF);
    check("t1_w_hs_strb",   w_hs_strb, 4'hF);
    check("t1_done_cycle",  done_log[0] - acc_log[0], 3);
    check("t1_done_resp",   resp_log[0], RESP_OKAY);

    // awready delayed 5 cycles, wready immediate.
    plan.push_back(mk(1, 5, 0, 0, RESP_OKAY, 4'hA, 32'h12345678, 4'h3));
    run_batch();
    check("t2_aw_hs_cycle", aw_hs_cyc - acc_log[0], 6);
    check("t2_done_count",  done_log.size(), 1);
    check("t2_done_cycle",  done_log[0] - acc_log[0], 8);

    // SLVERR with bvalid raised two cycles ahead of bready.
    plan.push_back(mk(0, 2, 2, -2, RESP_SLVERR, 4'h8, 32'hCAFEF00D, 4'hC));
    run_batch();
    check("t3_done_cycle", done_log[0] - acc_log[0], 5);
    check("t3_done_resp",  resp_log[0], 2'b10);

    // awready held low for 20 cycles: timeout after 8 outstanding cycles.
    to_rise = -1;
    plan.push_back(mk(0, 20, 0, 0, RESP_OKAY, 4'h2, 32'h0BADF00D, 4'h1));
    run_batch();
    check("t4_timeout_rise", to_rise - acc_log[0], 9);
    check("t4_done_cycle",   done_log[0] - acc_log[0], 23);
    check("t4_timeout_held", timeout, 1'b1);

    // Three back-to-back commands; the first accept clears the timeout.
    plan.push_back(mk(0, 0, 0, 0, RESP_OKAY, 4'h1, 32'h11111111, 4'hF));
    plan.push_back(mk(0, 0, 0, 0, RESP_OKAY, 4'h2, 32'h22222222, 4'hF));
    plan.push_back(mk(0, 0, 0, 0, RESP_OKAY, 4'h3, 32'h33333333, 4'hF));
    run_batch();
    check("t5_done_count", done_log.size(), 3);
    for (int i = 0; i < done_log.size(); i++)
      check("t5_done_cycle", done_log[i] - acc_log[0], 3 * (i + 1));
    check("t5_timeout_cleared", timeout, 1'b0);

    // Reset pulsed while the write is still in SEND.
    plan.push_back(mk(0, 10, 10, 0, RESP_OKAY, 4'h5, 32'h55555555, 4'hF));
    n = 0;
    while (!(active && (cyc - acc) >= 3) && n < 100) begin
      step();
      n++;
    end
    check("t6_reached_send", (active && (cyc - acc) >= 3), 1'b1);
    n_done = done_log.size();
    #2;
    cmp_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("t6_awvalid_async",    bus.awvalid, 1'b0);
    check("t6_wvalid_async",     bus.wvalid,  1'b0);
    check("t6_bready_async",     bus.bready,  1'b0);
    check("t6_done_valid_async", done_valid,  1'b0);
    check("t6_cmd_ready_async",  cmd_ready,   1'b0);
    active     = 1'b0;
    plan.delete();
    last_done  = -1;
    last_to    = 1'b0;
    last_resp  = 2'b00;
    idle_cnt   = 0;
    ready_from = 1 << 30;
    step();
    step();
    rst_n      = 1'b1;
    ready_from = cyc + 1;
    cmp_en     = 1'b1;
    step();
    check("t6_ready_after_release", cmd_ready, 1'b1);
    step();
    check("t6_no_done_after_reset", done_log.size(), n_done);

    // Randomized traffic against the timeline model.
    for (int i = 0; i < 40; i++) begin
      plan.push_back(mk($urandom_range(0, 3),
                        ($urandom_range(0, 9) == 0) ? $urandom_range(8, 12) : $urandom_range(0, 3),
                        $urandom_range(0, 4),
                        $urandom_range(0, 6) - 3,
                        2'($urandom), AW'($urandom), $urandom, SW'($urandom)));
    end
    run_batch();
    check("rand_done_count", done_log.size(), 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_lite_write_master.md
# axi_lite_write_master

AXI4-Lite write-channel initiator: accepts single-beat write commands from a local requester and drives them onto the AW, W and B channels of an AXI4-Lite slave. It is the initiator counterpart of the team's AXI-Lite write slave and sits between the register-programming controller and the slave port. It reports completion with the slave's write response and flags stalled transactions with a sticky timeout status.

## Interface
- ADDR_WIDTH, 4, address width in bits
- DATA_WIDTH, 32, data width in bits; must be a multiple of 8
- TIMEOUT_CYCLES, 256, cycles a transaction may stay outstanding before `timeout` sets; minimum 4
- clk  in  1  clock; all logic is rising-edge
- rst_n  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  block idle, can accept a command
- cmd_addr  in  ADDR_WIDTH  write address
- cmd_data  in  DATA_WIDTH  write data
- cmd_strb  in  DATA_WIDTH/8  byte strobes
- awaddr  out  ADDR_WIDTH  AW address
- awvalid  out  1  AW valid
- awready  in  1  AW ready
- wdata  out  DATA_WIDTH  W data
- wstrb  out  DATA_WIDTH/8  W strobes
- wvalid  out  1  W valid
- wready  in  1  W ready
- bresp  in  2  B response
- bvalid  in  1  B valid
- bready  out  1  B ready
- done_valid  out  1  one-cycle completion pulse
- done_resp  out  2  bresp captured at the B handshake; valid with done_valid
- timeout  out  1  sticky flag: current or last transaction exceeded TIMEOUT_CYCLES

## Operation
- FSM states: IDLE, SEND, RESP.
- IDLE behaviour:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: register addr, data and strb into awaddr, wdata and wstrb.
  - Set awvalid=1 and wvalid=1, clear timeout and the cycle counter, go to SEND.
- SEND behaviour:
  - AW and W are tracked independently with aw_done and w_done.
  - awvalid is held until awvalid&&awready is sampled, then cleared at that edge and aw_done set. The W channel works the same way.
  - awaddr, wdata and wstrb are stable while the corresponding valid is high.
  - When both are done (same edge or different edges): set bready=1, go to RESP.
  - Valid never depends combinationally on ready.
- RESP behaviour:
  - On bvalid&&bready: clear bready, set done_valid=1 for one cycle, set done_resp=bresp, go to IDLE.
  - bresp is passed through unchanged; SLVERR and DECERR are not retried.
- Timeout:
  - The counter runs in SEND and RESP and saturates at TIMEOUT_CYCLES.
  - When it reaches TIMEOUT_CYCLES, timeout is set to 1. The transaction continues, since AXI forbids withdrawing valid.
  - timeout stays set until the next command is accepted.
- cmd_addr, cmd_data and cmd_strb are ignored outside the accept cycle.

## Timing
- Reset values: cmd_ready=0, awvalid=0, wvalid=0, bready=0, done_valid=0, done_resp=0, timeout=0, awaddr/wdata/wstrb=0, state=IDLE.
- cmd_ready becomes 1 on the first rising edge after rst_n deasserts.
- All outputs are registered.
- Best-case latency, with the slave ready:
  - Command accepted at edge 0.
  - AW and W valid in cycle 1, handshakes at edge 1.
  - bready in cycle 2, B handshake at edge 2.
  - done_valid and cmd_ready both high in cycle 3.
  - Back-to-back throughput is one write per 3 cycles.
- cmd_ready is 0 from the cycle after accept until the cycle done_valid is high.
- Simultaneous events:
  - awready and wready asserted in the same cycle: both complete at that edge.
  - bvalid may be high before bready; the handshake occurs in the first cycle bready=1.
- Reset asserted mid-transaction: all outputs go to reset values immediately. The transaction is dropped and no done_valid is produced.

## Structure
- The shared package `axi_lite_pkg` holds:
  - response constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
  - the state encoding typedef for IDLE/SEND/RESP.
- No sub-module. The block is a single FSM with an embedded saturating counter of width clog2(TIMEOUT_CYCLES+1).

## Test plan
- Slave ready throughout, command addr=0x4, data=0xDEADBEEF, strb=0xF:
  - awaddr=0x4, wdata=0xDEADBEEF and wstrb=0xF are seen at the edge-1 handshakes.
  - done_valid=1 in cycle 3 with done_resp=OKAY.
- awready delayed 5 cycles, wready immediate:
  - wvalid drops after edge 1; awvalid is held 5 cycles with awaddr stable.
  - bready rises only after the AW handshake.
  - done_valid appears once.
- Slave returns bresp=2'b10 with bvalid asserted 2 cycles before bready:
  - The handshake occurs in the first bready cycle.
  - done_resp=2'b10.
- TIMEOUT_CYCLES=8 and awready held low for 20 cycles:
  - timeout=1 after 8 outstanding cycles; awvalid stays 1.
  - After awready rises, the transaction completes.
  - timeout clears on the next command accept.
- rst_n pulsed low while in SEND:
  - awvalid, wvalid, bready and done_valid go to 0 asynchronously, with no done_valid.
  - cmd_ready=1 one edge after release.
- Three back-to-back commands, all OKAY:
  - Three done_valid pulses at cycles 3, 6 and 9, with no overlapping valids.
